// File: rtl/lv_hv_adc_poll_if.sv
// OWT command/response bus seen by the HV ADC poller.
// master: the poller (drives the command request).
// slave : the OWT transceiver side (accepts commands, returns frames).
interface lv_hv_adc_poll_if #(
    parameter int OWT_CMD_BIT_NUM = 8
);
    logic                       owt_tx_rdy;
    logic                       owt_tx_req;
    logic [OWT_CMD_BIT_NUM-1:0] owt_tx_cmd;
    logic                       owt_rx_ack;
    logic [OWT_CMD_BIT_NUM-1:0] owt_rx_cmd;
    logic                       owt_rx_status;

    modport master (
        input  owt_tx_rdy,
        output owt_tx_req,
        output owt_tx_cmd,
        input  owt_rx_ack,
        input  owt_rx_cmd,
        input  owt_rx_status
    );

    modport slave (
        output owt_tx_rdy,
        input  owt_tx_req,
        input  owt_tx_cmd,
        output owt_rx_ack,
        output owt_rx_cmd,
        output owt_rx_status
    );
endinterface

// File: rtl/lv_hv_adc_poll.sv
// LV-side poller for the HV ADC data register.
// Periodically issues an OWT read of ADC_REQ_ADDR, waits for the matching
// response with a bounded ack timeout, retries up to MAX_RETRY times and
// flags abandoned transactions with a sticky error.
// Optional macro LV_HV_POLL_STAT_EN adds an 8-bit saturating count of
// abandoned transactions on o_fail_cnt; without it o_fail_cnt is 0.
module lv_hv_adc_poll #(
    parameter int                OWT_CMD_BIT_NUM = 8,
    parameter int                REG_AW          = 7,
    parameter logic [REG_AW-1:0] ADC_REQ_ADDR    = 7'h1F,
    parameter int                PERIOD_W        = 16,
    parameter int                ACK_TIMEOUT     = 1024,
    parameter int                MAX_RETRY       = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_poll_en,
    input  logic [PERIOD_W-1:0] i_poll_period,
    input  logic                i_err_clr,
    lv_hv_adc_poll_if.master    owt,
    output logic                o_poll_busy,
    output logic                o_poll_done,
    output logic [1:0]          o_retry_cnt,
    output logic                o_timeout_err,
    output logic [7:0]          o_fail_cnt
);
    localparam int          TO_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [1:0]  MAX_R   = 2'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_WAIT     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [PERIOD_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]          retry_q, retry_d;
    logic                req_q, req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fail_inc;

    logic                xfer;
    logic                rx_match;
    logic                ack_ok;
    logic                ack_bad;
    logic                to_hit;
    logic [PERIOD_W-1:0] period_last;
    logic                wait_done;

    // The requested command is a fixed read of the polled register.
    assign owt.owt_tx_cmd = {1'b0, ADC_REQ_ADDR};

    // Handshake, response match and wait-period decode.
    assign xfer     = req_q & owt.owt_tx_rdy;
    assign rx_match = owt.owt_rx_ack
                    & owt.owt_rx_cmd[OWT_CMD_BIT_NUM-1]
                    & (owt.owt_rx_cmd[REG_AW-1:0] == ADC_REQ_ADDR);
    assign ack_ok   = rx_match & ~owt.owt_rx_status;
    assign ack_bad  = rx_match &  owt.owt_rx_status;
    assign to_hit   = (to_cnt_q == TO_LAST);
    // A period of 0 behaves as 1; the compare is >= so a period lowered
    // below the running count ends the wait on the next edge.
    assign period_last = (i_poll_period == '0) ? '0 : i_poll_period - 1'b1;
    assign wait_done   = (wait_cnt_q >= period_last);

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        wait_cnt_d = wait_cnt_q;
        retry_d    = retry_q;
        done_d     = 1'b0;
        // Clear first so that a same-cycle error set overrides it.
        err_d      = err_q & ~i_err_clr;
        fail_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_poll_en) begin
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                // A handshake wins over a same-cycle enable drop.
                if (xfer) begin
                    state_d  = ST_WAIT_ACK;
                    to_cnt_d = '0;
                end else if (!i_poll_en) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A good ack on the expiry cycle counts as success.
                if (ack_ok) begin
                    done_d     = 1'b1;
                    retry_d    = '0;
                    wait_cnt_d = '0;
                    state_d    = i_poll_en ? ST_WAIT : ST_IDLE;
                end else if (ack_bad || to_hit) begin
                    if (retry_q < MAX_R) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d      = 1'b1;
                        fail_inc   = 1'b1;
                        retry_d    = '0;
                        wait_cnt_d = '0;
                        state_d    = i_poll_en ? ST_WAIT : ST_IDLE;
                    end
                end
            end

            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (!i_poll_en) begin
                    state_d = ST_IDLE;
                end else if (wait_done) begin
                    state_d = ST_SEND;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_d  = (state_d == ST_SEND);
        busy_d = (state_d == ST_SEND) || (state_d == ST_WAIT_ACK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            wait_cnt_q <= '0;
            retry_q    <= '0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            retry_q    <= retry_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign owt.owt_tx_req = req_q;
    assign o_poll_busy    = busy_q;
    assign o_poll_done    = done_q;
    assign o_retry_cnt    = retry_q;
    assign o_timeout_err  = err_q;

`ifdef LV_HV_POLL_STAT_EN
    logic [7:0] fail_cnt_q;

    // Saturating count of abandoned transactions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fail_cnt_q <= '0;
        end else if (fail_inc && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_q <= fail_cnt_q + 1'b1;
        end
    end

    assign o_fail_cnt = fail_cnt_q;
`else
    logic unused_fail_inc;

    assign unused_fail_inc = fail_inc;
    assign o_fail_cnt      = '0;
`endif

endmodule

// File: tb/tb_lv_hv_adc_poll.sv
// Directed bench for lv_hv_adc_poll with ACK_TIMEOUT shortened to 16.
module tb_lv_hv_adc_poll;
    localparam int TO = 16;
`ifdef LV_HV_POLL_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_poll_en;
    logic [15:0] i_poll_period;
    logic        i_err_clr;
    logic        o_poll_busy;
    logic        o_poll_done;
    logic [1:0]  o_retry_cnt;
    logic        o_timeout_err;
    logic [7:0]  o_fail_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    lv_hv_adc_poll_if #(.OWT_CMD_BIT_NUM(8)) owt ();

    lv_hv_adc_poll #(
        .OWT_CMD_BIT_NUM(8),
        .REG_AW         (7),
        .ADC_REQ_ADDR   (7'h1F),
        .PERIOD_W       (16),
        .ACK_TIMEOUT    (TO),
        .MAX_RETRY      (3)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_poll_en    (i_poll_en),
        .i_poll_period(i_poll_period),
        .i_err_clr    (i_err_clr),
        .owt          (owt),
        .o_poll_busy  (o_poll_busy),
        .o_poll_done  (o_poll_done),
        .o_retry_cnt  (o_retry_cnt),
        .o_timeout_err(o_timeout_err),
        .o_fail_cnt   (o_fail_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        else n_pass++;
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_req(input int budget);
        int k;
        k = 0;
        while (!owt.owt_tx_req && k < budget) begin
            tick();
            k++;
        end
        chk("wait_req", owt.owt_tx_req, 1);
    endtask

    task automatic ack_pulse(input logic [7:0] cmd, input logic st);
        owt.owt_rx_ack    = 1'b1;
        owt.owt_rx_cmd    = cmd;
        owt.owt_rx_status = st;
        tick();
        owt.owt_rx_ack    = 1'b0;
        owt.owt_rx_cmd    = 8'h00;
        owt.owt_rx_status = 1'b0;
    endtask

    // One attempt that times out: transfer, then TO edges later the failure.
    task automatic timeout_attempt();
        tick();
        tick_n(TO - 1);
        chk("to_not_early", o_poll_busy & ~owt.owt_tx_req, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_poll_en = 1'b0; i_poll_period = 16'd4; i_err_clr = 1'b0;
        owt.owt_tx_rdy = 1'b1; owt.owt_rx_ack = 1'b0;
        owt.owt_rx_cmd = 8'h00; owt.owt_rx_status = 1'b0;
        tick_n(3);
        chk("rst_req",   owt.owt_tx_req, 0);
        chk("rst_busy",  o_poll_busy, 0);
        chk("rst_done",  o_poll_done, 0);
        chk("rst_retry", o_retry_cnt, 0);
        chk("rst_err",   o_timeout_err, 0);
        chk("rst_fail",  o_fail_cnt, 0);
        chk("tx_cmd",    owt.owt_tx_cmd, 8'h1F);
        i_rst = 1'b0;

        // Normal poll, period 4, ack three cycles after the transfer.
        i_poll_en = 1'b1;
        tick();
        chk("first_req", owt.owt_tx_req, 1);
        chk("first_busy", o_poll_busy, 1);
        tick();
        chk("xfer_req_low", owt.owt_tx_req, 0);
        chk("xfer_busy", o_poll_busy, 1);
        tick_n(2);
        ack_pulse(8'h9F, 1'b0);
        chk("ok_done", o_poll_done, 1);
        chk("ok_busy", o_poll_busy, 0);
        chk("ok_retry", o_retry_cnt, 0);
        tick();
        chk("done_pulse", o_poll_done, 0);
        chk("wait_req0", owt.owt_tx_req, 0);
        tick_n(2);
        chk("wait_req2", owt.owt_tx_req, 0);
        tick();
        chk("next_req_p4", owt.owt_tx_req, 1);
        tick();
        tick_n(2);
        ack_pulse(8'h9F, 1'b0);
        chk("ok2_done", o_poll_done, 1);

        // Backpressure: request held while tx_rdy is low.
        owt.owt_tx_rdy = 1'b0;
        tick_n(3);
        chk("bp_pre", owt.owt_tx_req, 0);
        tick();
        chk("bp_rise", owt.owt_tx_req, 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("bp_hold", owt.owt_tx_req, 1);
        end
        owt.owt_tx_rdy = 1'b1;
        tick();
        chk("bp_xfer", owt.owt_tx_req, 0);
        tick_n(TO - 2);
        chk("bp_no_to", o_retry_cnt, 0);
        chk("bp_busy", o_poll_busy, 1);
        ack_pulse(8'h9F, 1'b0);
        chk("bp_done", o_poll_done, 1);

        // Retry twice on error status, then success.
        wait_req(8);
        tick();
        tick_n(2);
        ack_pulse(8'h9F, 1'b1);
        chk("rt_cnt1", o_retry_cnt, 1);
        chk("rt_req1", owt.owt_tx_req, 1);
        tick();
        tick_n(2);
        ack_pulse(8'h9F, 1'b1);
        chk("rt_cnt2", o_retry_cnt, 2);
        tick();
        tick_n(2);
        ack_pulse(8'h9F, 1'b0);
        chk("rt_done", o_poll_done, 1);
        chk("rt_clr", o_retry_cnt, 0);
        chk("rt_err", o_timeout_err, 0);

        // Exhausted retries: four timed-out attempts.
        wait_req(8);
        for (int a = 1; a <= 3; a++) begin
            timeout_attempt();
            chk("ex_retry", o_retry_cnt, a);
            chk("ex_rereq", owt.owt_tx_req, 1);
        end
        timeout_attempt();
        chk("ex_err", o_timeout_err, 1);
        chk("ex_fail", o_fail_cnt, STAT);
        chk("ex_retry0", o_retry_cnt, 0);
        chk("ex_done", o_poll_done, 0);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("err_clr", o_timeout_err, 0);

        // Second abandon with err_clr on the failing edge: set wins.
        wait_req(8);
        for (int a = 1; a <= 3; a++) timeout_attempt();
        tick();
        tick_n(TO - 1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        chk("clr_vs_set", o_timeout_err, 1);
        chk("fail2", o_fail_cnt, 2 * STAT);

        // Non-matching acks are ignored; timeout follows.
        wait_req(8);
        tick();
        tick_n(2);
        ack_pulse(8'h9E, 1'b0);
        chk("flt_addr", o_poll_done, 0);
        ack_pulse(8'h1F, 1'b0);
        chk("flt_msb", o_poll_done, 0);
        chk("flt_busy", o_poll_busy, 1);
        tick_n(TO - 5);
        chk("flt_pre_to", o_retry_cnt, 0);
        tick();
        chk("flt_to", o_retry_cnt, 1);
        // Matching ack exactly on the expiry edge.
        tick();
        tick_n(TO - 1);
        ack_pulse(8'h9F, 1'b0);
        chk("race_done", o_poll_done, 1);
        chk("race_retry", o_retry_cnt, 0);

        // Enable dropped in WAIT_ACK: transaction completes, then idle.
        wait_req(8);
        tick();
        i_poll_en = 1'b0;
        tick_n(2);
        chk("en_busy", o_poll_busy, 1);
        ack_pulse(8'h9F, 1'b0);
        chk("en_done", o_poll_done, 1);
        tick_n(5);
        chk("en_idle_req", owt.owt_tx_req, 0);
        chk("en_idle_busy", o_poll_busy, 0);

        // Period 0 behaves as 1.
        i_poll_period = 16'd0;
        i_poll_en = 1'b1;
        tick();
        chk("p0_req", owt.owt_tx_req, 1);
        tick();
        tick_n(2);
        ack_pulse(8'h9F, 1'b0);
        chk("p0_done", o_poll_done, 1);
        tick();
        chk("p0_next", owt.owt_tx_req, 1);

        // Enable dropped in SEND before a transfer.
        owt.owt_tx_rdy = 1'b0;
        i_poll_en = 1'b0;
        tick();
        chk("send_drop_req", owt.owt_tx_req, 0);
        chk("send_drop_busy", o_poll_busy, 0);

        // Reset in WAIT_ACK.
        owt.owt_tx_rdy = 1'b1;
        i_poll_en = 1'b1;
        tick_n(2);
        chk("pre_rst_busy", o_poll_busy, 1);
        i_rst = 1'b1;
        tick();
        chk("mr_req",  owt.owt_tx_req, 0);
        chk("mr_busy", o_poll_busy, 0);
        chk("mr_done", o_poll_done, 0);
        chk("mr_err",  o_timeout_err, 0);
        chk("mr_fail", o_fail_cnt, 0);
        i_rst = 1'b0;
        i_poll_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lv_hv_adc_poll.md
# lv_hv_adc_poll

LV-side poller that periodically issues OWT read requests for the HV ADC data register and supervises the responses. It sits directly upstream of the LV shadow-register stage. The OWT responses it triggers return on the `i_owt_rx_*` bus, which the shadow stage captures into its ADC1/ADC2 copies. The block enforces request pacing, an ack timeout with bounded retry, and sticky error reporting.

## Interface
- `OWT_CMD_BIT_NUM`, default 8: OWT command width. MSB is the write/response flag; the low bits are the register address.
- `REG_AW`, default 7: register address width. Must equal `OWT_CMD_BIT_NUM-1`.
- `ADC_REQ_ADDR`, default 7'h1F: HV register address polled.
- `PERIOD_W`, default 16: width of the poll period input.
- `ACK_TIMEOUT`, default 1024: cycles allowed between request acceptance and ack. Must be ≥ 2.
- `MAX_RETRY`, default 3: retries after the first attempt before declaring failure.
- `i_clk` in, 1: the single clock of the block.
- `i_rst` in, 1: synchronous, active-high reset.
- `i_poll_en` in, 1: polling enable (level).
- `i_poll_period` in, PERIOD_W: idle cycles between transactions. A value of 0 is treated as 1.
- `i_err_clr` in, 1: one-cycle pulse that clears `o_timeout_err`.
- `i_owt_tx_rdy` in, 1: the OWT transmitter can accept a command.
- `o_owt_tx_req` out, 1: command valid.
- `o_owt_tx_cmd` out, OWT_CMD_BIT_NUM: requested command, constant `{1'b0, ADC_REQ_ADDR}` (read).
- `i_owt_rx_ack` in, 1: one-cycle pulse marking a received frame.
- `i_owt_rx_cmd` in, OWT_CMD_BIT_NUM: command of the received frame.
- `i_owt_rx_status` in, 1: 0 = normal, 1 = error.
- `o_poll_busy` out, 1: high in SEND and WAIT_ACK.
- `o_poll_done` out, 1: one-cycle pulse on a successful response.
- `o_retry_cnt` out, 2: retries used in the current transaction.
- `o_timeout_err` out, 1: sticky flag, set when a transaction is abandoned.
- `o_fail_cnt` out, 8: saturating count of abandoned transactions.

## Operation
- States are IDLE, SEND, WAIT_ACK and WAIT. All outputs are registered.
- **IDLE**: if `i_poll_en`=1, go to SEND.
- **SEND**: hold `o_owt_tx_req`=1.
  - Transfer occurs on a cycle where `o_owt_tx_req` and `i_owt_tx_rdy` are both 1. On transfer, go to WAIT_ACK and clear the timeout counter.
  - If `i_poll_en` drops before transfer, drop the request and return to IDLE.
- **WAIT_ACK**: a matching response is `i_owt_rx_ack`=1 with `i_owt_rx_cmd[OWT_CMD_BIT_NUM-1]`=1 and `i_owt_rx_cmd[REG_AW-1:0]`=`ADC_REQ_ADDR`. Non-matching acks are ignored.
  - **Success** (match with status=0): pulse `o_poll_done`, clear the retry count.
  - **Failure**: a match with status=1, or the timeout counter reaching `ACK_TIMEOUT-1` with no match.
    - If retry count < `MAX_RETRY`: increment it and return to SEND.
    - Otherwise: set `o_timeout_err`, increment `o_fail_cnt` (saturating at 255), and clear the retry count.
  - After a success or an abandoned transaction: go to WAIT if `i_poll_en`=1, else IDLE.
  - A transfer already made is always completed, even if `i_poll_en` drops.
- **WAIT**: count cycles from 0.
  - At count = `max(i_poll_period,1)-1`, go to SEND.
  - If `i_poll_en`=0, go to IDLE on the next cycle.
  - Changing `i_poll_period` mid-wait takes effect immediately against the running count. If the count already exceeds the new value, go to SEND on the next cycle.
- **Simultaneous events**:
  - Matching ack in the same cycle as timeout expiry: the ack wins.
  - `i_err_clr` in the same cycle as an error set: the set wins.
- Acks arriving in IDLE, SEND or WAIT are ignored.

## Timing
- **Reset**: state IDLE, all counters 0, and every output 0 except `o_owt_tx_cmd`, which is constant.
- **Reset mid-operation**: the transaction is abandoned with no `o_poll_done` and no error set.
- **First request**: `i_poll_en` sampled high at edge N → `o_owt_tx_req`=1 from cycle N+1.
- **After a transfer**: handshake at edge M → WAIT_ACK from M+1.
  - With no ack, the timeout fires at edge M+`ACK_TIMEOUT`.
  - On a retry, `o_owt_tx_req` reasserts in the following cycle.
- **Success**: matching ack at edge K → `o_poll_done`=1 in cycle K+1, and WAIT is entered in cycle K+1.
- **Next request**: the next `o_owt_tx_req` rises `max(P,1)` cycles after entering WAIT, where P is `i_poll_period`.
- **Error clear**: `i_err_clr` at edge E → `o_timeout_err`=0 from cycle E+1.

## Configuration
- Macro `LV_HV_POLL_STAT_EN`:
  - **Defined**: the 8-bit `o_fail_cnt` saturating counter is implemented.
  - **Undefined**: `o_fail_cnt` is tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- **Normal poll**: period=4, tx_rdy=1, matching ack with status=0 three cycles after each transfer → `o_poll_done` pulses, the next request rises 4 cycles after WAIT entry, retry count stays 0.
- **Backpressure**: tx_rdy low for 10 cycles → `o_owt_tx_req` held high for 10 cycles, transfer on the first cycle with tx_rdy=1, no timeout started before it.
- **Retry then success**: ack status=1 twice, then status=0 → `o_retry_cnt` goes 1 then 2, `o_poll_done`=1, `o_timeout_err`=0.
- **Exhausted retries**: no ack, `ACK_TIMEOUT`=16 → four attempts 16 cycles apart, then `o_timeout_err`=1 and `o_fail_cnt`=1 (0 without the macro). `i_err_clr` together with a new failure → the flag remains 1.
- **Filtering and races**:
  - An ack with address 7'h1E or MSB=0 → ignored and a timeout follows.
  - A matching ack on the expiry cycle → success.
- **Enable/reset**:
  - `i_poll_en` dropped in WAIT_ACK → the transaction completes, then IDLE.
  - `i_rst` asserted in WAIT_ACK → all outputs 0 the next cycle.
